stream_demux4: RTL and testbench

STREAM_DEMUX4 -- requirements
Module: stream_demux4

---
 rtl/stream_demux4.sv | 89 ++++++++
 tb/tb_stream_demux4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux4
// Brief    : 1-to-4 valid/ready stream demultiplexer with one output register
//            per lane, select or round-robin routing, and per-lane beat counters.
// Revision : 1.0
// ============================================================================
module stream_demux4 #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    in_sel,
    input  logic          rr_mode,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [N-1:0]  out_data0,
    output logic [N-1:0]  out_data1,
    output logic [N-1:0]  out_data2,
    output logic [N-1:0]  out_data3,
    output logic [4*CW-1:0] lane_cnt,
    output logic [1:0]    rr_ptr
);

    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [1:0]    c_ptr_one = 2'd1;

    logic [3:0]    r_valid;
    logic [N-1:0]  r_data [4];
    logic [CW-1:0] r_cnt  [4];
    logic [1:0]    r_rr_ptr;

    logic [1:0]    w_dest;
    logic          w_in_ready;
    logic          w_accept;

    // Ready looks only at the destination lane, so a stall elsewhere never blocks us.
    always_comb begin
        w_dest     = rr_mode ? r_rr_ptr : in_sel;
        w_in_ready = ~rst & (~r_valid[w_dest] | out_ready[w_dest]);
        w_accept   = in_valid & w_in_ready;
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic w_load;
            assign w_load = w_accept & (w_dest == 2'(k));

            // Load wins over drain so a lane can sustain one beat per cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                    r_cnt[k]   <= '0;
                end else if (w_load) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                    r_cnt[k]   <= r_cnt[k] + c_cnt_one;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end

            assign lane_cnt[k*CW +: CW] = r_cnt[k];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept && rr_mode) begin
            r_rr_ptr <= r_rr_ptr + c_ptr_one;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign rr_ptr    = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux4
// Brief    : Table-driven self-checking bench for stream_demux4.
// Revision : 1.0
// ============================================================================
module tb_stream_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        rr_mode;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  out_data0, out_data1, out_data2, out_data3;
    logic [31:0] lane_cnt;
    logic [1:0]  rr_ptr;

    int n_vec = 0;
    int n_err = 0;

    stream_demux4 #(.N(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .rr_mode(rr_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .lane_cnt(lane_cnt), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    logic [7:0] od [4];
    always_comb begin
        od[0] = out_data0;
        od[1] = out_data1;
        od[2] = out_data2;
        od[3] = out_data3;
    end

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic       rr;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [3:0] e_ov;
        logic [1:0] lane;
        logic [7:0] e_data;
        logic [7:0] e_cnt;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(logic vld, logic [1:0] sel, logic rr, logic [7:0] data,
                                logic [3:0] ordy, logic e_rdy, logic [3:0] e_ov,
                                logic [1:0] lane, logic [7:0] e_data, logic [7:0] e_cnt,
                                logic [1:0] e_ptr);
        vec_t v;
        v.vld = vld; v.sel = sel; v.rr = rr; v.data = data; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.lane = lane; v.e_data = e_data;
        v.e_cnt = e_cnt; v.e_ptr = e_ptr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check ready mid-cycle, then check state after the edge.
    task automatic apply(input int i);
        in_valid  = tbl[i].vld;
        in_sel    = tbl[i].sel;
        rr_mode   = tbl[i].rr;
        in_data   = tbl[i].data;
        out_ready = tbl[i].ordy;
        #3;
        check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        @(posedge clk); #1;
        check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
        check($sformatf("v%0d out_data%0d", i, tbl[i].lane), 32'(od[tbl[i].lane]), 32'(tbl[i].e_data));
        check($sformatf("v%0d lane_cnt%0d", i, tbl[i].lane),
              32'(lane_cnt[tbl[i].lane*8 +: 8]), 32'(tbl[i].e_cnt));
        check($sformatf("v%0d rr_ptr", i), 32'(rr_ptr), 32'(tbl[i].e_ptr));
    endtask

    task automatic beat(input logic [1:0] sel, input logic [7:0] data, input logic [3:0] ordy);
        in_valid = 1'b1; in_sel = sel; in_data = data; out_ready = ordy;
        @(posedge clk); #1;
    endtask

    initial begin
        //            vld sel rr data   ordy     rdy ov       ln data  cnt ptr
        tbl[0]  = mk(1, 2, 0, 8'hA5, 4'b0000, 1, 4'b0100, 2, 8'hA5, 1, 0);
        tbl[1]  = mk(1, 2, 0, 8'h5A, 4'b0000, 0, 4'b0100, 2, 8'hA5, 1, 0);
        tbl[2]  = mk(1, 0, 0, 8'h3C, 4'b0000, 1, 4'b0101, 0, 8'h3C, 1, 0);
        tbl[3]  = mk(1, 2, 0, 8'h77, 4'b0100, 1, 4'b0101, 2, 8'h77, 2, 0);
        tbl[4]  = mk(0, 1, 0, 8'hEE, 4'b1111, 1, 4'b0000, 0, 8'h3C, 1, 0);
        tbl[5]  = mk(1, 3, 0, 8'h99, 4'b0111, 1, 4'b1000, 3, 8'h99, 1, 0);
        tbl[6]  = mk(1, 3, 0, 8'h98, 4'b0111, 0, 4'b1000, 3, 8'h99, 1, 0);
        tbl[7]  = mk(0, 3, 0, 8'h97, 4'b0000, 0, 4'b1000, 3, 8'h99, 1, 0);
        tbl[8]  = mk(1, 3, 1, 8'h10, 4'b1111, 1, 4'b0001, 0, 8'h10, 2, 1);
        tbl[9]  = mk(1, 3, 1, 8'h11, 4'b1111, 1, 4'b0010, 1, 8'h11, 1, 2);
        tbl[10] = mk(1, 3, 1, 8'h12, 4'b1111, 1, 4'b0100, 2, 8'h12, 3, 3);
        tbl[11] = mk(1, 3, 1, 8'h13, 4'b1111, 1, 4'b1000, 3, 8'h13, 2, 0);
        tbl[12] = mk(1, 3, 1, 8'h14, 4'b1111, 1, 4'b0001, 0, 8'h14, 3, 1);
        tbl[13] = mk(1, 3, 1, 8'h15, 4'b1111, 1, 4'b0010, 1, 8'h15, 2, 2);
        tbl[14] = mk(1, 0, 1, 8'h20, 4'b0000, 1, 4'b0110, 2, 8'h20, 4, 3);
        tbl[15] = mk(1, 0, 1, 8'h21, 4'b0000, 1, 4'b1110, 3, 8'h21, 3, 0);
        tbl[16] = mk(1, 0, 1, 8'h22, 4'b0000, 1, 4'b1111, 0, 8'h22, 4, 1);
        tbl[17] = mk(1, 0, 1, 8'h23, 4'b0010, 1, 4'b1111, 1, 8'h23, 3, 2);
        tbl[18] = mk(1, 0, 1, 8'h24, 4'b0100, 1, 4'b1111, 2, 8'h24, 5, 3);
        tbl[19] = mk(1, 0, 1, 8'h25, 4'b0111, 0, 4'b1000, 3, 8'h21, 3, 3);
        tbl[20] = mk(1, 0, 1, 8'h25, 4'b1000, 1, 4'b1000, 3, 8'h25, 4, 0);
        tbl[21] = mk(1, 1, 0, 8'h30, 4'b0000, 1, 4'b1010, 1, 8'h30, 4, 0);

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; rr_mode = 1'b0; out_ready = '0;
        #1 rst = 1'b1;
        #2;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h0);
        check("reset lane_cnt", lane_cnt, 32'h0);
        check("reset rr_ptr", 32'(rr_ptr), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) apply(i);

        // Back-to-back beats through lane 1 while its consumer is always ready.
        rr_mode = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_sel = 2'd1; in_data = 8'(i); out_ready = 4'b0010;
            #3;
            check($sformatf("thru%0d in_ready", i), 32'(in_ready), 32'h1);
            @(posedge clk); #1;
            check($sformatf("thru%0d out_data1", i), 32'(out_data1), 32'(i));
            check($sformatf("thru%0d out_valid1", i), 32'(out_valid[1]), 32'h1);
        end
        check("thru lane_cnt1", 32'(lane_cnt[15:8]), 32'd12);

        // Empty everything, then fill lanes 0..2 round-robin so rr_ptr sits at 3.
        in_valid = 1'b0; out_ready = 4'b1111;
        @(posedge clk); #1;
        rr_mode = 1'b1;
        beat(2'd0, 8'h40, 4'b0000);
        beat(2'd0, 8'h41, 4'b0000);
        beat(2'd0, 8'h42, 4'b0000);
        in_valid = 1'b0;
        check("prefill out_valid", 32'(out_valid), 32'h7);
        check("prefill rr_ptr", 32'(rr_ptr), 32'h3);

        // Asynchronous reset mid-cycle must clear state before the next edge.
        #2 rst = 1'b1;
        #1;
        check("async out_valid", 32'(out_valid), 32'h0);
        check("async rr_ptr", 32'(rr_ptr), 32'h0);
        check("async lane_cnt", lane_cnt, 32'h0);
        check("async out_data0", 32'(out_data0), 32'h0);
        check("async in_ready", 32'(in_ready), 32'h0);
        rr_mode = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5E; out_ready = 4'b0000;
        @(posedge clk); #1;
        check("held reset out_valid", 32'(out_valid), 32'h0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("first accept out_valid", 32'(out_valid), 32'h4);
        check("first accept out_data2", 32'(out_data2), 32'h5E);

        // 256 accepts into lane 0 wrap its counter back to zero.
        for (int i = 0; i < 256; i++) beat(2'd0, 8'(i), 4'b0001);
        in_valid = 1'b0;
        check("wrap lane_cnt0", 32'(lane_cnt[7:0]), 32'h0);
        check("wrap lane_cnt others", 32'(lane_cnt[31:8]), 32'h000100);
        check("wrap out_data0", 32'(out_data0), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
